// File: rtl/uart_rx.sv
// 8N1 UART receiver with an RX FIFO behind a 4-register bus window; response 1 cycle after every request.
// No backpressure: requests are always accepted, and a byte arriving at a full FIFO is dropped and sets sticky overflow.
module uart_rx #(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115_200,
  parameter int RxFifoDepth    = 8
) (
  input  logic        clk_sys_i,
  input  logic        rst_sys_ni,
  input  logic        device_req_i,
  input  logic [31:0] device_addr_i,
  input  logic        device_we_i,
  input  logic [3:0]  device_be_i,
  input  logic [31:0] device_wdata_i,
  output logic        device_rvalid_o,
  output logic [31:0] device_rdata_o,
  input  logic        uart_rx_i,
  output logic        rx_irq_o
);
  localparam int ClkPerBit = ClockFrequency / BaudRate;
  localparam int CntW      = $clog2(ClkPerBit);
  localparam int PtrW      = $clog2(RxFifoDepth);
  localparam int CountW    = $clog2(RxFifoDepth + 1);
  localparam logic [CntW-1:0] HalfLoad = CntW'(ClkPerBit / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(ClkPerBit - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_e;

  logic rx_meta, rx_s;
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_s    <= rx_meta;
    end
  end

  state_e          state_q, state_d;
  logic [CntW-1:0] baud_cnt_q, cnt_load_val;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            tick, cnt_load, shift_en, bit_clr, stop_ok_vld, stop_bad;

  assign tick = (baud_cnt_q == '0);

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!rx_s) state_d = START;
      START:     if (tick) state_d = rx_s ? IDLE : DATA;
      DATA:      if (tick && bit_idx_q == 3'd7) state_d = STOP;
      STOP:      if (tick) state_d = rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = FullLoad;
    shift_en     = 1'b0;
    bit_clr      = 1'b0;
    stop_ok_vld  = 1'b0;
    stop_bad     = 1'b0;
    case (state_q)
      IDLE: if (!rx_s) begin
        cnt_load     = 1'b1;
        cnt_load_val = HalfLoad;
      end
      START: if (tick && !rx_s) begin
        cnt_load = 1'b1;
        bit_clr  = 1'b1;
      end
      DATA: if (tick) begin
        cnt_load = 1'b1;
        shift_en = 1'b1;
      end
      STOP: if (tick) begin
        stop_ok_vld = rx_s;
        stop_bad    = !rx_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
    end else begin
      if (cnt_load)   baud_cnt_q <= cnt_load_val;
      else if (!tick) baud_cnt_q <= baud_cnt_q - CntW'(1);
      if (bit_clr)       bit_idx_q <= '0;
      else if (shift_en) bit_idx_q <= bit_idx_q + 3'd1;
      if (shift_en) shift_q <= {rx_s, shift_q[7:1]};
    end
  end

  logic [7:0]        fifo_mem [RxFifoDepth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q;
  logic              not_empty, full, rd_data_req, pop, push_ok, ovf_set;

  assign not_empty   = (count_q != '0);
  assign full        = (count_q == CountW'(RxFifoDepth));
  assign rd_data_req = device_req_i && !device_we_i && (device_addr_i[3:2] == 2'd0);
  assign pop         = rd_data_req && not_empty;
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign push_ok     = stop_ok_vld && (!full || pop);
  assign ovf_set     = stop_ok_vld && full && !pop;

  always_ff @(posedge clk_sys_i) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CountW'(1);
        2'b01:   count_q <= count_q - CountW'(1);
        default: ;
      endcase
    end
  end

  logic ctrl_wr, irq_en_q, overflow_q, frame_err_q;
  assign ctrl_wr = device_req_i && device_we_i && (device_addr_i[3:2] == 2'd2) && device_be_i[0];

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      irq_en_q    <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= device_wdata_i[0];
      overflow_q  <= ovf_set  || (overflow_q  && !(ctrl_wr && device_wdata_i[1]));
      frame_err_q <= stop_bad || (frame_err_q && !(ctrl_wr && device_wdata_i[2]));
    end
  end

  logic [31:0] rdata_d;
  always_comb begin
    rdata_d = '0;
    case (device_addr_i[3:2])
      2'd0:    if (not_empty) rdata_d = {1'b1, 23'b0, fifo_mem[rd_ptr_q]};
      2'd1:    rdata_d = {16'b0, 8'(count_q), 4'b0, frame_err_q, overflow_q, full, not_empty};
      2'd2:    rdata_d = {31'b0, irq_en_q};
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      device_rvalid_o <= 1'b0;
      device_rdata_o  <= '0;
    end else begin
      device_rvalid_o <= device_req_i;
      if (device_req_i) device_rdata_o <= device_we_i ? 32'b0 : rdata_d;
    end
  end

  assign rx_irq_o = irq_en_q && not_empty;

  logic unused_bus;
  assign unused_bus = ^{device_addr_i[31:4], device_addr_i[1:0], device_be_i[3:1], device_wdata_i[31:3]};
endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx against a queue-based model of the receive FIFO and flags.
module tb_uart_rx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = 4'hF;
  logic        rx = 1'b1;
  logic        rvalid;
  logic [31:0] rdata;
  logic        irq;

  uart_rx #(.ClockFrequency(50_000_000), .BaudRate(5_000_000), .RxFifoDepth(4)) dut (
    .clk_sys_i(clk), .rst_sys_ni(rst_n), .device_req_i(req), .device_addr_i(addr),
    .device_we_i(we), .device_be_i(be), .device_wdata_i(wdata),
    .device_rvalid_o(rvalid), .device_rdata_o(rdata), .uart_rx_i(rx), .rx_irq_o(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Model: FIFO contents plus sticky flags, updated per whole frame / bus access.
  logic [7:0] mq[$];
  bit m_ov, m_fe;

  function automatic logic [31:0] m_status();
    return {16'h0, 8'(mq.size()), 4'h0, m_fe, m_ov, mq.size() == 4, mq.size() != 0};
  endfunction

  function automatic logic [31:0] m_pop();
    if (mq.size() == 0) return 32'h0;
    return {1'b1, 23'h0, mq.pop_front()};
  endfunction

  function automatic void m_frame(input logic [7:0] b, input bit stop);
    if (!stop) m_fe = 1'b1;
    else if (mq.size() < 4) mq.push_back(b);
    else m_ov = 1'b1;
  endfunction

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
    req = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    req = 1'b0;
    v = rvalid; d = rdata;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] wd, output logic v);
    req = 1'b1; we = 1'b1; addr = a; wdata = wd;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    v = rvalid;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (10) @(negedge clk);
    end
    rx = 1'b1;
    m_frame(b, stop);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    repeat (3) @(negedge clk);
    n_checks++; if ({rvalid, rdata, irq} !== 34'h0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", {rvalid, rdata, irq}); end
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(32'h4, d, v);
    n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL reset_rvalid: got %b want 1", v); end
    n_checks++; if (d !== m_status()) begin n_fail++; $display("FAIL reset_status: got %h want %h", d, m_status()); end
    bus_read(32'h8, d, v);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", d); end
  endtask

  task automatic test_single();
    logic [31:0] d, e; logic v;
    send_frame(8'hA5, 1'b1);
    bus_read(32'h4, d, v);
    n_checks++; if (d !== m_status()) begin n_fail++; $display("FAIL single_status1: got %h want %h", d, m_status()); end
    e = m_pop();
    bus_read(32'h0, d, v);
    n_checks++; if (d !== e) begin n_fail++; $display("FAIL single_rd1: got %h want %h", d, e); end
    @(negedge clk);
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL single_rvalid_pulse: got %b want 0", rvalid); end
    e = m_pop();
    bus_read(32'h0, d, v);
    n_checks++; if (d !== e) begin n_fail++; $display("FAIL single_rd_empty: got %h want %h", d, e); end
    bus_read(32'h4, d, v);
    n_checks++; if (d !== m_status()) begin n_fail++; $display("FAIL single_status0: got %h want %h", d, m_status()); end
  endtask

  // Stop sample is 2 (sync) + 5 (half bit) + 90 (nine bits) cycles after the pin falls.
  task automatic test_irq();
    logic [31:0] d, e; logic v; logic [9:0] f;
    bus_write(32'h8, 32'h1, v);
    n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL irq_wr_ack: got %b want 1", v); end
    f = {1'b1, 8'h3C, 1'b0};
    for (int k = 0; k < 100; k++) begin
      rx = f[k / 10];
      @(negedge clk);
      if (k + 1 == 97) begin
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_before_push: got %b want 0", irq); end
      end
      if (k + 1 == 98) begin
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b want 1", irq); end
      end
    end
    rx = 1'b1;
    m_frame(8'h3C, 1'b1);
    e = m_pop();
    bus_read(32'h0, d, v);
    n_checks++; if (d !== e) begin n_fail++; $display("FAIL irq_rd: got %h want %h", d, e); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall: got %b want 0", irq); end
  endtask

  task automatic test_overflow();
    logic [31:0] d, e; logic v;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    bus_read(32'h4, d, v);
    n_checks++; if (d !== m_status()) begin n_fail++; $display("FAIL ovf_status: got %h want %h", d, m_status()); end
    for (int i = 0; i < 4; i++) begin
      e = m_pop();
      bus_read(32'h0, d, v);
      n_checks++; if (d !== e) begin n_fail++; $display("FAIL ovf_rd%0d: got %h want %h", i, d, e); end
    end
    bus_write(32'h8, 32'h2, v);
    m_ov = 1'b0;
    bus_read(32'h4, d, v);
    n_checks++; if (d !== m_status()) begin n_fail++; $display("FAIL ovf_clear: got %h want %h", d, m_status()); end
  endtask

  task automatic test_frame_err();
    logic [31:0] d, e; logic v;
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h66, 1'b1);
    bus_read(32'h4, d, v);
    n_checks++; if (d !== m_status()) begin n_fail++; $display("FAIL ferr_status: got %h want %h", d, m_status()); end
    e = m_pop();
    bus_read(32'h0, d, v);
    n_checks++; if (d !== e) begin n_fail++; $display("FAIL ferr_rd: got %h want %h", d, e); end
    bus_write(32'h8, 32'h4, v);
    m_fe = 1'b0;
    bus_read(32'h4, d, v);
    n_checks++; if (d !== m_status()) begin n_fail++; $display("FAIL ferr_clear: got %h want %h", d, m_status()); end
  endtask

  task automatic test_glitch();
    logic [31:0] d, e; logic v; logic [7:0] b;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    bus_read(32'h4, d, v);
    n_checks++; if (d !== m_status()) begin n_fail++; $display("FAIL glitch_status: got %h want %h", d, m_status()); end
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1);
    e = m_pop();
    bus_read(32'h0, d, v);
    n_checks++; if (d !== e) begin n_fail++; $display("FAIL glitch_resync: got %h want %h", d, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    for (int i = 0; i < 3; i++) send_frame(8'($urandom_range(0, 255)), 1'b1);
    req = 1'b1; we = 1'b0; addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) req = 1'b0;
      e = m_pop();
      n_checks++; if (rdata !== e || rvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_rd%0d: got %h/%b want %h/1", i, rdata, rvalid, e); end
    end
  endtask

  task automatic test_simul_push_pop();
    logic [31:0] d, e; logic v; logic [7:0] b5; logic [9:0] f;
    for (int i = 0; i < 4; i++) send_frame(8'($urandom_range(0, 255)), 1'b1);
    b5 = 8'($urandom_range(0, 255));
    f = {1'b1, b5, 1'b0};
    e = 32'h0;
    for (int k = 0; k < 100; k++) begin
      rx = f[k / 10];
      @(negedge clk);
      if (k + 1 == 97) begin
        req = 1'b1; we = 1'b0; addr = 32'h0;
        e = m_pop();
      end
      if (k + 1 == 98) begin
        req = 1'b0;
        n_checks++; if (rdata !== e) begin n_fail++; $display("FAIL simul_rd: got %h want %h", rdata, e); end
      end
    end
    rx = 1'b1;
    m_frame(b5, 1'b1);
    bus_read(32'h4, d, v);
    n_checks++; if (d !== m_status()) begin n_fail++; $display("FAIL simul_status: got %h want %h", d, m_status()); end
    for (int i = 0; i < 4; i++) begin
      e = m_pop();
      bus_read(32'h0, d, v);
      n_checks++; if (d !== e) begin n_fail++; $display("FAIL simul_drain%0d: got %h want %h", i, d, e); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d, e; logic v;
    bus_write(32'h8, 32'h1, v);
    send_frame(8'($urandom_range(0, 255)), 1'b1);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL rst_irq_pre: got %b want 1", irq); end
    rx = 1'b0;
    repeat (25) @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h4;
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({rvalid, rdata, irq} !== 34'h0) begin n_fail++; $display("FAIL rst_mid_outputs: got %h want 0", {rvalid, rdata, irq}); end
    mq.delete(); m_ov = 1'b0; m_fe = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bus_read(32'h4, d, v);
    n_checks++; if (d !== m_status()) begin n_fail++; $display("FAIL rst_mid_status: got %h want %h", d, m_status()); end
    bus_read(32'h8, d, v);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_mid_ctrl: got %h want 0", d); end
    send_frame(8'($urandom_range(0, 255)), 1'b1);
    e = m_pop();
    bus_read(32'h0, d, v);
    n_checks++; if (d !== e) begin n_fail++; $display("FAIL rst_mid_rx: got %h want %h", d, e); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_irq();
    test_overflow();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_simul_push_pop();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
